latency_credit_fifo: RTL and testbench
======================================

# latency_credit_fifo

- Receiving end of a fixed-latency pipeline (e.g. VRAM/flash read paths built from registered delay stages) whose downstream consumer can stall.
- Issues credits upstream, tracks every issued request in flight, and buffers the results when they arrive `LATENCY` cycles later.
- Presents results on a valid/ready port, guaranteeing no result is ever dropped.
- Flags any arrival that does not match an issued request.

## Interface

Parameters:
- `WIDTH`, 16, data width of results.
- `LATENCY`, 2, cycles from an accepted issue to its `in_valid`; must be ≥ 1.
- `DEPTH`, 4, buffer entries; must be ≥ 1. Any integer is legal; power of 2 not required.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `issue_valid` in 1: upstream wants to launch a request this cycle.
- `issue_ready` out 1: credit available; a request is accepted when `issue_valid && issue_ready`.
- `in_valid` in 1: result arriving from the pipeline.
- `in_data` in `WIDTH`: result payload.
- `out_valid` out 1: buffer head valid.
- `out_data` out `WIDTH`: buffer head data.
- `out_ready` in 1: consumer accepts the head; pop occurs on `out_valid && out_ready`.
- `error` out 1: sticky protocol-violation flag.

## Operation

- **Credit rule:** `issue_ready = (inflight + count) < DEPTH`.
  - Combinational from registers only; it does not depend on `issue_valid`, `in_valid` or `out_ready`.
  - `inflight`: accepted issues whose results have not yet arrived. Width `$clog2(DEPTH+1)`.
  - `count`: buffer occupancy. Width `$clog2(DEPTH+1)`.
- **Expected-arrival tracking:**
  - A 1-bit shift line of length `LATENCY` carries `issue_valid && issue_ready`.
  - Its output, `expect`, is high exactly in the cycle a result must arrive.
- **Per-cycle `inflight` update:**
  - +1 on accept, −1 when `expect` is high.
  - Both in the same cycle leaves it unchanged.
- **Buffer write:** on `expect && in_valid`, `in_data` is written at `wr_ptr`.
  - Credit accounting guarantees `count < DEPTH` in that cycle, so the write always succeeds.
- **Buffer pop:** on `out_valid && out_ready`, `rd_ptr` advances.
- **Pointer wrap:** pointers wrap explicitly from `DEPTH-1` to 0, by compare, not by modulo.
- **Per-cycle `count` update:** +1 on write, −1 on pop, unchanged when both occur.
- **Pop credit is not immediate:** a slot freed by a pop becomes available as `issue_ready` in the next cycle.
- **Error conditions** (either one sets `error` until reset):
  - `in_valid && !expect`: an unexpected arrival. The data is discarded and nothing is written.
  - `expect && !in_valid`: a missing arrival. `inflight` still decrements and nothing is written.
- **Outputs:**
  - `out_valid = (count != 0)`.
  - `out_data` = memory at `rd_ptr`, show-ahead; stable while `out_valid && !out_ready`.
- **Reset:** clears `count`, `inflight`, both pointers, the shift line and `error`.
  - Memory contents are not cleared.
  - A reset mid-operation abandons all in-flight results. Upstream must reset its pipeline in the same cycle; any arrival after reset is flagged as unexpected.

## Timing

- Reset values: `issue_ready`=1, `out_valid`=0, `error`=0; `out_data` is don't-care.
- An issue accepted at cycle t expects its arrival at cycle t+`LATENCY`.
- Arrival at cycle a gives `out_valid`=1 from cycle a+1. Minimum issue-to-out latency is `LATENCY`+1.
- Sustained throughput is 1 result per cycle when `DEPTH` ≥ `LATENCY`+1 and `out_ready` is held at 1. Smaller `DEPTH` throttles issues.
- With `out_ready`=0, at most `DEPTH` issues are accepted, and `issue_ready` stays low until a pop.
- Empty with a same-cycle arrival and `out_ready`=1: no pop that cycle, since `out_valid` was 0. The data appears next cycle.
- Full with a same-cycle pop and accept: legal only if `inflight`+`count` < `DEPTH` was true at the start of that cycle.

## Structure

- Use `delay_ff` (`DELAY`=`LATENCY`, `WIDTH`=1) as the expected-arrival shift line; it is the only sub-module.
- The buffer is an inline register array with an `out_data` read mux; no RAM inference is required.
- No shared package; all widths derive locally from the parameters.

## Test plan

- **Streaming:** `LATENCY`=2, `DEPTH`=4, `out_ready`=1; issue 8 back-to-back; model returns 0x00A0..0x00A7 two cycles after each issue → `out_data` shows A0..A7 in order, one per cycle, starting at cycle 3; `issue_ready` never drops; `error`=0.
- **Stall fill:** `out_ready`=0 with continuous `issue_valid` → exactly 4 accepts; `issue_ready`=0 from cycle 4; `count` reaches 4. Release `out_ready` → one extra credit per pop, each visible one cycle after the pop; no data lost.
- **Unexpected arrival:** inject `in_valid` with no prior issue, data 0xDEAD → `error`=1 and stays 1; `out_valid` stays 0.
- **Missing arrival:** issue once and withhold `in_valid` → `error` set at cycle t+2; `inflight` returns to 0 and `issue_ready`=1.
- **Wrap with odd depth:** `DEPTH`=3, `LATENCY`=1; 10 issues with random `out_ready` → in-order output of all 10 values; pointers wrap 2→0 correctly.
- **Reset mid-flight:** assert `reset` with 2 results in flight and 2 buffered → next cycle `out_valid`=0, `issue_ready`=1, `error`=0. A stale arrival one cycle later sets `error`.

Source files
------------

// File: rtl/delay_ff.sv
// delay_ff: fixed-length register delay line.
//   clk   : clock
//   reset : synchronous, active-high; clears every stage
//   d_i   : input sample (WIDTH bits)
//   q_o   : d_i delayed by exactly DELAY cycles (DELAY >= 1)
module delay_ff #(
  parameter int DELAY = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [DELAY-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DELAY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DELAY-1];

endmodule

// File: rtl/latency_credit_fifo.sv
// latency_credit_fifo: receiving end of a fixed-latency pipeline.
// Hands out credits upstream, tracks issued requests in flight, buffers
// their results and presents them on a valid/ready port. A result slot is
// reserved at issue time, so an arrival always finds room.
//   clk, reset               : clock, synchronous active-high reset
//   issue_valid/issue_ready  : upstream request launch (credit handshake)
//   in_valid/in_data         : result arriving LATENCY cycles after issue
//   out_valid/out_data/out_ready : show-ahead result port
//   error                    : sticky; arrival without an issue, or a
//                              missing arrival where one was due
module latency_credit_fifo #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             error
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_W  = (CW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [CW-1:0]    inflight_q, inflight_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             error_q, error_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic accept, expect_arr, wr_en, pop;

  // Registers only: in-flight requests plus held results must fit the buffer.
  assign issue_ready = ({1'b0, inflight_q} + {1'b0, count_q}) < DEPTH_W;
  assign accept      = issue_valid & issue_ready;
  assign out_valid   = (count_q != '0);
  assign out_data    = mem_q[rd_ptr_q];
  assign error       = error_q;
  assign wr_en       = expect_arr & in_valid;
  assign pop         = out_valid & out_ready;

  // High exactly in the cycle an accepted issue's result is due.
  delay_ff #(
    .DELAY(LATENCY),
    .WIDTH(1)
  ) u_expect (
    .clk  (clk),
    .reset(reset),
    .d_i  (accept),
    .q_o  (expect_arr)
  );

  always_comb begin
    inflight_d = inflight_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    // A due slot always retires, arrived or not; xor catches both faults.
    error_d    = error_q | (in_valid ^ expect_arr);

    case ({accept, expect_arr})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: ;
    endcase

    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase

    if (wr_en) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    if (pop)   rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      error_q    <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      error_q    <= error_d;
    end
  end

  // Storage is not reset; out_data is only meaningful while out_valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_latency_credit_fifo.sv
// Two instances: A (LATENCY=2, DEPTH=4) and B (LATENCY=1, DEPTH=3), driven
// in lockstep. A queue-based model predicts every output each cycle.
module tb_latency_credit_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [1:0]       iv, inv, ordy, ir, ov, er;
  logic [1:0][15:0] ind, od;

  latency_credit_fifo #(.WIDTH(16), .LATENCY(2), .DEPTH(4)) u_a (
    .clk(clk), .reset(reset), .issue_valid(iv[0]), .issue_ready(ir[0]),
    .in_valid(inv[0]), .in_data(ind[0]), .out_valid(ov[0]), .out_data(od[0]),
    .out_ready(ordy[0]), .error(er[0]));

  latency_credit_fifo #(.WIDTH(16), .LATENCY(1), .DEPTH(3)) u_b (
    .clk(clk), .reset(reset), .issue_valid(iv[1]), .issue_ready(ir[1]),
    .in_valid(inv[1]), .in_data(ind[1]), .out_valid(ov[1]), .out_data(od[1]),
    .out_ready(ordy[1]), .error(er[1]));

  // model: pending arrival cycles and buffered data, as ring queues
  int          pq [2][64];
  int          ph [2], pt [2];
  logic [15:0] bq [2][64];
  int          bh [2], bt [2];
  bit          merr [2];
  // upstream pipeline: scheduled returns indexed by cycle
  bit          rv   [2][128];
  logic [15:0] rdat [2][128];
  int          acc_cnt [2];

  int it, n_chk, n_fail;
  bit c_rst, c_inj, c_hold;
  int c_iv, c_ordy;  // 0 = low, 1 = high, 2 = random

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, it, act, want);
    end
  endtask

  task automatic step();
    for (int k = 0; k < 2; k++) begin
      int lat, dep, slot;
      bit v, iv_k, ir_k, or_k, m_rdy, acc, ex, wr, pp;
      logic [15:0] d;
      lat  = (k == 0) ? 2 : 1;
      dep  = (k == 0) ? 4 : 3;
      slot = it % 128;
      v    = rv[k][slot];
      d    = v ? rdat[k][slot] : 16'hDEAD;
      rv[k][slot] = 1'b0;
      iv_k = (c_iv == 1) || (c_iv == 2 && $urandom_range(0, 1) == 1);
      or_k = (c_ordy == 1) || (c_ordy == 2 && $urandom_range(0, 1) == 1);
      ir_k = v | c_inj;
      iv[k] = iv_k; inv[k] = ir_k; ind[k] = d; ordy[k] = or_k;
      if (c_rst) begin
        ph[k] = 0; pt[k] = 0; bh[k] = 0; bt[k] = 0; merr[k] = 1'b0;
      end else begin
        m_rdy = ((pt[k] - ph[k]) + (bt[k] - bh[k])) < dep;
        acc   = iv_k && m_rdy;
        ex    = (pt[k] > ph[k]) && (pq[k][ph[k] % 64] == it);
        wr    = ex && ir_k;
        pp    = (bt[k] > bh[k]) && or_k;
        if (ir_k != ex) merr[k] = 1'b1;
        if (pp) bh[k]++;
        if (wr) begin bq[k][bt[k] % 64] = d; bt[k]++; end
        if (ex) ph[k]++;
        if (acc) begin
          pq[k][pt[k] % 64] = it + lat; pt[k]++;
          if (!c_hold) begin
            rv[k][(it + lat) % 128]   = 1'b1;
            rdat[k][(it + lat) % 128] = (c_iv == 2) ? 16'($urandom) : 16'h00A0 + 16'(acc_cnt[k]);
          end
          acc_cnt[k]++;
        end
      end
    end
    reset = c_rst;
    @(negedge clk);
    it++;
    for (int k = 0; k < 2; k++) begin
      bit m_rdy;
      m_rdy = ((pt[k] - ph[k]) + (bt[k] - bh[k])) < ((k == 0) ? 4 : 3);
      chk($sformatf("issue_ready[%0d]", k), 32'(ir[k]), 32'(m_rdy));
      chk($sformatf("out_valid[%0d]", k), 32'(ov[k]), 32'(bt[k] > bh[k]));
      chk($sformatf("error[%0d]", k), 32'(er[k]), 32'(merr[k]));
      if (bt[k] > bh[k])
        chk($sformatf("out_data[%0d]", k), 32'(od[k]), 32'(bq[k][bh[k] % 64]));
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; it = 0;
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; pt[k] = 0; bh[k] = 0; bt[k] = 0; merr[k] = 1'b0; acc_cnt[k] = 0;
      for (int j = 0; j < 128; j++) rv[k][j] = 1'b0;
    end
    reset = 1'b1; iv = '0; inv = '0; ind = '0; ordy = '0;
    c_rst = 1'b1; c_inj = 1'b0; c_hold = 1'b0; c_iv = 0; c_ordy = 0;
    @(negedge clk);
    step(); step();
    chk("reset_issue_ready", 32'(ir[0]), 32'd1);
    chk("reset_out_valid", 32'(ov[0]), 32'd0);
    chk("reset_error", 32'(er[0]), 32'd0);
    c_rst = 1'b0;

    // streaming: 8 back-to-back issues, A0..A7 out one per cycle
    c_iv = 1; c_ordy = 1;
    for (int p = 0; p < 14; p++) begin
      if (p == 8) c_iv = 0;
      step();
      if (p < 8) chk("stream_issue_ready", 32'(ir[0]), 32'd1);
      if (p >= 2 && p < 10) begin
        chk("stream_out_valid", 32'(ov[0]), 32'd1);
        chk("stream_out_data", 32'(od[0]), 32'h00A0 + 32'(p - 2));
      end
    end
    chk("stream_error", 32'(er[0]), 32'd0);

    // stall fill: exactly 4 credits, then release
    c_ordy = 0; c_iv = 1;
    for (int p = 0; p < 8; p++) begin
      step();
      chk("fill_issue_ready", 32'(ir[0]), (p < 3) ? 32'd1 : 32'd0);
    end
    chk("fill_out_valid", 32'(ov[0]), 32'd1);
    c_ordy = 1;
    for (int p = 0; p < 12; p++) step();
    c_iv = 0;
    for (int p = 0; p < 10; p++) step();

    // unexpected arrival
    c_inj = 1'b1; step(); c_inj = 1'b0;
    chk("unexp_error", 32'(er[0]), 32'd1);
    chk("unexp_out_valid", 32'(ov[0]), 32'd0);
    for (int p = 0; p < 3; p++) begin
      step();
      chk("unexp_sticky", 32'(er[0]), 32'd1);
    end
    c_rst = 1'b1; step(); c_rst = 1'b0;
    chk("clear_error", 32'(er[0]), 32'd0);

    // missing arrival: single issue, result withheld
    c_hold = 1'b1; c_iv = 1; step(); c_iv = 0; c_hold = 1'b0;
    step();
    chk("missing_early", 32'(er[0]), 32'd0);
    step();
    chk("missing_error", 32'(er[0]), 32'd1);
    chk("missing_ready", 32'(ir[0]), 32'd1);
    for (int p = 0; p < 3; p++) step();
    c_rst = 1'b1; step(); c_rst = 1'b0;

    // random traffic (B exercises odd-depth wrap)
    c_iv = 2; c_ordy = 2;
    for (int p = 0; p < 300; p++) step();
    c_iv = 0; c_ordy = 1;
    for (int p = 0; p < 10; p++) step();

    // reset with 2 buffered and 2 in flight, then a stale arrival
    c_ordy = 0; c_iv = 1;
    for (int p = 0; p < 4; p++) step();
    c_iv = 0; c_rst = 1'b1; step(); c_rst = 1'b0;
    chk("midreset_out_valid", 32'(ov[0]), 32'd0);
    chk("midreset_ready", 32'(ir[0]), 32'd1);
    chk("midreset_error", 32'(er[0]), 32'd0);
    c_ordy = 1; step();
    chk("stale_error", 32'(er[0]), 32'd1);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
